// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl (+ full_adder)
//  Purpose  : Bit-serial add/subtract sequencer around one single-bit adder.
//  Revision : 1.0  initial release
// ============================================================================

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   input  logic             op_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             busy
);

   localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_start_ready;
   logic             r_res_valid;
   logic             r_busy;
   logic             w_sum;
   logic             w_cout;

   // The adder sees only registered operands, so no port reaches an output.
   full_adder u_fa (
      .a    (r_sa[0]),
      .b    (r_sb[0]),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_sa          <= '0;
         r_sb          <= '0;
         r_result      <= '0;
         r_carry       <= 1'b0;
         r_cnt         <= '0;
         r_start_ready <= 1'b1;
         r_res_valid   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid && r_start_ready) begin
                  // Subtract is A + ~B + 1; the +1 rides in on the carry.
                  r_sa          <= op_a;
                  r_sb          <= op_sub ? ~op_b : op_b;
                  r_carry       <= op_sub ? 1'b1 : cin_in;
                  r_cnt         <= '0;
                  r_result      <= '0;
                  r_state       <= S_RUN;
                  r_start_ready <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end
            S_RUN: begin
               r_result <= {w_sum, r_result[WIDTH-1:1]};
               r_carry  <= w_cout;
               r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
               if (r_cnt == C_LAST) begin
                  r_state     <= S_DONE;
                  r_res_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_state       <= S_IDLE;
                  r_res_valid   <= 1'b0;
                  r_busy        <= 1'b0;
                  r_start_ready <= 1'b1;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_res_valid   <= 1'b0;
               r_busy        <= 1'b0;
               r_start_ready <= 1'b1;
            end
         endcase
      end
   end

   assign start_ready = r_start_ready;
   assign res_valid   = r_res_valid;
   assign busy        = r_busy;
   assign res_sum     = r_result;
   assign res_cout    = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
//  Revision : 1.0  initial release
// ============================================================================

module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] op_a = '0;
   logic [7:0] op_b = '0;
   logic       cin_in = 1'b0;
   logic       op_sub = 1'b0;
   logic       res_ready = 1'b0;
   logic       start_valid8 = 1'b0;
   logic       start_valid2 = 1'b0;

   logic       start_ready8, res_valid8, res_cout8, busy8;
   logic [7:0] res_sum8;
   logic       start_ready2, res_valid2, res_cout2, busy2;
   logic [1:0] res_sum2;

   int checks = 0;
   int errors = 0;
   int cur_w  = 8;

   logic       m_start_ready, m_res_valid, m_res_cout;
   logic [7:0] m_res_sum;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start_valid(start_valid8), .start_ready(start_ready8),
      .op_a(op_a), .op_b(op_b), .cin_in(cin_in), .op_sub(op_sub),
      .res_valid(res_valid8), .res_ready(res_ready), .res_sum(res_sum8),
      .res_cout(res_cout8), .busy(busy8)
   );

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start_valid(start_valid2), .start_ready(start_ready2),
      .op_a(op_a[1:0]), .op_b(op_b[1:0]), .cin_in(cin_in), .op_sub(op_sub),
      .res_valid(res_valid2), .res_ready(res_ready), .res_sum(res_sum2),
      .res_cout(res_cout2), .busy(busy2)
   );

   always_comb begin
      m_start_ready = start_ready8;
      m_res_valid   = res_valid8;
      m_res_cout    = res_cout8;
      m_res_sum     = res_sum8;
      if (cur_w == 2) begin
         m_start_ready = start_ready2;
         m_res_valid   = res_valid2;
         m_res_cout    = res_cout2;
         m_res_sum     = {6'b0, res_sum2};
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint model(input int w, input longint a, input longint b,
                                    input bit cin, input bit sub);
      longint mask = (longint'(1) << w) - 1;
      return (a & mask) + (sub ? (~b & mask) : (b & mask)) + (sub ? 1 : longint'(cin));
   endfunction

   // Runs one operation on the 8-bit instance; returns the result and the
   // number of edges from the accepting edge until res_valid is seen.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, output logic [7:0] sum, output logic cout,
                         output int lat);
      int n;
      op_a = a; op_b = b; cin_in = cin; op_sub = sub;
      start_valid8 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!start_ready8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("start_timeout", 1, 0);
      @(posedge clk);
      #1;
      start_valid8 = 1'b0;
      op_a = $urandom; op_b = $urandom; cin_in = $urandom; op_sub = $urandom;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (res_valid8) begin
            lat = i;
            break;
         end
      end
      sum  = res_sum8;
      cout = res_cout8;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("idle_start_ready", start_ready8, 1);
      chk("idle_busy", busy8, 0);
   endtask

   task automatic rand_run(input int w);
      longint exp_q[$];
      longint e, act;
      int got, cyc, last;
      got = 0; cyc = 0; last = -1;
      cur_w = w;
      if (w == 8) start_valid8 = 1'b1; else start_valid2 = 1'b1;
      while (got < 500 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (m_res_valid && res_ready) begin
            act = (longint'(m_res_cout) << w) | longint'(m_res_sum);
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_result", act, -1);
            end else begin
               e = exp_q.pop_front();
               chk((w == 8) ? "rand8_result" : "rand2_result", act, e);
            end
            got++;
         end
         if (m_start_ready) begin
            if (last >= 0) chk("issue_interval_ok", (cyc - last) >= (w + 2), 1);
            last = cyc;
            exp_q.push_back(model(w, op_a, op_b, cin_in, op_sub));
         end
         @(posedge clk);
         #1;
         op_a = $urandom; op_b = $urandom; cin_in = $urandom; op_sub = $urandom;
         res_ready = $urandom_range(0, 1);
      end
      if (got < 500) chk("rand_timeout", got, 500);
      start_valid8 = 1'b0;
      start_valid2 = 1'b0;
      res_ready = 1'b1;
      repeat (w + 4) @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] sum, hold_sum;
      logic       cout, hold_cout;
      int         lat;
      bit         seen;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
      vecs[4] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1};
      vecs[5] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0};
      vecs[6] = '{8'h3C, 8'h11, 1'b0, 1'b0, 8'h4D, 1'b0};
      vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready8, 1);
      chk("rst_res_valid", res_valid8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_res_sum", res_sum8, 0);
      chk("rst_res_cout", res_cout8, 0);
      chk("rst_start_ready_w2", start_ready2, 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed table
      foreach (vecs[i]) begin
         do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, sum, cout, lat);
         chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
         chk($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
         chk($sformatf("vec%0d_latency", i), lat, 8);
      end

      // Reset abort during RUN cycle 4
      op_a = 8'h3C; op_b = 8'h11; cin_in = 1'b0; op_sub = 1'b0;
      start_valid8 = 1'b1;
      @(negedge clk);
      chk("abort_start_ready", start_ready8, 1);
      @(posedge clk);
      #1;
      start_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_busy_before", busy8, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_res_valid", res_valid8, 0);
      chk("abort_busy", busy8, 0);
      chk("abort_start_ready_now", start_ready8, 1);
      chk("abort_res_sum", res_sum8, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid8 || busy8) seen = 1'b1;
      end
      chk("abort_no_result", seen, 0);
      @(posedge clk);
      #1;
      do_op8(8'h01, 8'h01, 1'b0, 1'b0, sum, cout, lat);
      chk("post_abort_sum", sum, 8'h02);

      // Backpressure in DONE
      op_a = 8'h5A; op_b = 8'h33; cin_in = 1'b0; op_sub = 1'b0;
      start_valid8 = 1'b1;
      @(posedge clk);
      #1;
      start_valid8 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = res_valid8;
      end
      chk("bp_reached_done", seen, 1);
      hold_sum  = res_sum8;
      hold_cout = res_cout8;
      chk("bp_sum", hold_sum, 8'h8D);
      chk("bp_cout", hold_cout, 0);
      for (int i = 0; i < 6; i++) begin
         op_a = $urandom; op_b = $urandom; op_sub = $urandom;
         start_valid8 = ~start_valid8;
         @(negedge clk);
         chk("bp_sum_stable", res_sum8, hold_sum);
         chk("bp_cout_stable", res_cout8, hold_cout);
         chk("bp_start_ready_low", start_ready8, 0);
         chk("bp_res_valid_held", res_valid8, 1);
         @(posedge clk);
         #1;
      end
      start_valid8 = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("bp_idle_start_ready", start_ready8, 1);
      chk("bp_idle_busy", busy8, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_stray_start", busy8, 0);

      // Random back-to-back
      rand_run(8);
      rand_run(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around one instance of the team's single-bit `full_adder`. It accepts two WIDTH-bit operands over a valid/ready handshake and drives them through the shared adder one bit per clock, LSB first. It then holds the WIDTH-bit result and carry-out until the consumer accepts it. The block trades latency for area in datapaths that need occasional wide additions.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock for all state.
- RST  input  1  asynchronous, active-high reset.
- START_VALID  input  1  requester presents an operation.
- START_READY  output  1  block can accept an operation; high only in IDLE.
- OP_A  input  WIDTH  first operand; sampled only on start handshake.
- OP_B  input  WIDTH  second operand; sampled only on start handshake.
- CIN_IN  input  1  carry-in for add; sampled on start handshake and ignored when OP_SUB=1.
- OP_SUB  input  1  0 selects A+B+CIN_IN; 1 selects A-B, implemented as A+~B+1.
- RES_VALID  output  1  result registers hold a completed operation.
- RES_READY  input  1  consumer accepts the result.
- RES_SUM  output  WIDTH  result, modulo 2^WIDTH.
- RES_COUT  output  1  final carry. For subtract, 1 means no borrow (A>=B unsigned).
- BUSY  output  1  high in RUN or DONE.

## Operation
- States and transitions:
  - IDLE to RUN on START_VALID && START_READY.
  - RUN to DONE when the bit counter reaches WIDTH-1.
  - DONE to IDLE on RES_VALID && RES_READY.
- Start handshake, on the accepting edge:
  - Capture OP_A into shift register SA.
  - Capture OP_B, inverted when OP_SUB=1, into shift register SB.
  - Load the carry register: CIN_IN for add, 1 for subtract.
  - Clear the bit counter and the result register.
- The `full_adder` inputs are A=SA[0], B=SB[0] and CIN=carry register. They are fed only from registers, never from ports.
- Each RUN cycle:
  - Shift the result right, inserting adder SUM at the MSB.
  - Load adder COUT into the carry register.
  - Shift SA and SB right by one.
  - Increment the counter.
- After WIDTH RUN cycles, the result register equals the full sum and the carry register equals the final carry.
- DONE state:
  - RES_SUM and RES_COUT are driven directly from the result and carry registers.
  - Both stay stable for as long as RES_VALID is high and RES_READY is low.
- OP_A, OP_B, CIN_IN and OP_SUB changing outside the start handshake have no effect.
- START_VALID during RUN or DONE is not accepted. START_READY is low, and the requester must hold its request.
- Arithmetic is unsigned modulo 2^WIDTH. Signed overflow is not reported.
- Counter width is clog2(WIDTH). Its terminal value is WIDTH-1 and it never wraps beyond that.

## Timing
- Reset (asynchronous, takes effect immediately and holds while RST=1):
  - State IDLE; SA, SB, result, carry and counter all 0.
  - RES_VALID=0, RES_SUM=0, RES_COUT=0, BUSY=0, START_READY=1.
- Reset asserted in RUN or DONE aborts the operation. Outputs return to reset values without waiting for a clock edge, and the pending result is lost.
- Latency: with the start handshake on edge k, RES_VALID rises after edge k+WIDTH, i.e. exactly WIDTH cycles of RUN.
- RES_READY held high in DONE produces this sequence:
  - The handshake at edge m returns the block to IDLE.
  - START_READY is high after edge m.
  - The next operation can be accepted at edge m+1.
  - Minimum issue interval is WIDTH+2 cycles.
- RES_READY may be high before RES_VALID. In that case DONE lasts exactly one cycle.
- START_READY and RES_VALID are pure decodes of the state register. There are no combinational paths from input ports to outputs.

## Test plan
- Reset abort:
  - Stimulus (WIDTH=8): start A=0x3C, B=0x11, then assert RST during RUN cycle 4 for 2 cycles.
  - Response: RES_VALID=0, BUSY=0, START_READY=1 and RES_SUM=0 within the same cycle; no result appears afterwards.
  - Then run a fresh start A=0x01, B=0x01 and check RES_SUM=0x02.
- Basic add (WIDTH=8): A=0x0F, B=0x01, CIN_IN=0 -> RES_SUM=0x10, RES_COUT=0, with RES_VALID high exactly 8 cycles after the accepting edge.
- Carry chain:
  - A=0xFF, B=0x01, CIN_IN=0 -> RES_SUM=0x00, RES_COUT=1.
  - A=0xFF, B=0xFF, CIN_IN=1 -> RES_SUM=0xFF, RES_COUT=1.
  - A=0x00, B=0x00, CIN_IN=1 -> RES_SUM=0x01, RES_COUT=0.
- Subtract:
  - OP_SUB=1, A=0x07, B=0x05, CIN_IN=1 -> RES_SUM=0x02, RES_COUT=1 (CIN_IN ignored).
  - OP_SUB=1, A=0x05, B=0x07 -> RES_SUM=0xFE, RES_COUT=0.
- Backpressure:
  - Stimulus: hold RES_READY=0 for 6 cycles in DONE, changing OP_A/OP_B and pulsing START_VALID meanwhile.
  - Response: RES_SUM and RES_COUT stay stable, START_READY stays 0 and no start is accepted.
  - Then raise RES_READY and check IDLE on the next cycle, with START_READY=1.
- Random back-to-back:
  - Run 500 random A, B, CIN_IN, OP_SUB vectors with WIDTH=8 and again with WIDTH=2.
  - START_VALID is held high and RES_READY is randomly toggled.
  - Every result must match the reference model {COUT,SUM} = A + (SUB ? ~B : B) + (SUB ? 1 : CIN_IN).
  - Every issue interval must be >= WIDTH+2 cycles.
